// File: rtl/perspective_pixel_map.sv
// Inverse perspective mapper: one display pixel in, one source-frame coordinate out.
// MAC -> sign/abs prep -> QBITS-step restoring division (x and y in lockstep) -> result.
module perspective_pixel_map #(
  parameter int QBITS = 11,
  parameter int X_MAX = 639,
  parameter int Y_MAX = 479
)(
  input  logic        clk,
  input  logic        reset,
  input  logic [67:0] p1_inv,
  input  logic [68:0] p2_inv,
  input  logic [78:0] p3_inv,
  input  logic [67:0] p4_inv,
  input  logic [68:0] p5_inv,
  input  logic [78:0] p6_inv,
  input  logic [58:0] p7_inv,
  input  logic [59:0] p8_inv,
  input  logic [70:0] p9_inv,
  input  logic        req_valid,
  input  logic [9:0]  req_x,
  input  logic [8:0]  req_y,
  output logic        req_ready,
  output logic        out_valid,
  output logic [9:0]  src_x,
  output logic [8:0]  src_y,
  output logic        src_ok
);
  localparam int W  = 73 + QBITS;
  localparam int CW = $clog2(QBITS);
  localparam logic [QBITS-1:0] X_LIM = QBITS'(X_MAX);
  localparam logic [QBITS-1:0] Y_LIM = QBITS'(Y_MAX);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MAC  = 3'd1;
  localparam logic [2:0] S_PREP = 3'd2;
  localparam logic [2:0] S_DIV  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [9:0]         x_q, x_d;
  logic [8:0]         y_q, y_d;
  logic signed [67:0] c1_q, c1_d, c4_q, c4_d;
  logic signed [68:0] c2_q, c2_d, c5_q, c5_d;
  logic signed [78:0] c3_q, c3_d, c6_q, c6_d;
  logic signed [58:0] c7_q, c7_d;
  logic signed [59:0] c8_q, c8_d;
  logic signed [70:0] c9_q, c9_d;
  // numerators/denominator hold the signed sums after MAC, then magnitudes/remainders
  logic [80:0]        numx_q, numx_d, numy_q, numy_d;
  logic [72:0]        den_q, den_d;
  logic               bad_x_q, bad_x_d, bad_y_q, bad_y_d;
  logic [QBITS-1:0]   qx_q, qx_d, qy_q, qy_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d, src_ok_q, src_ok_d;
  logic [9:0]         src_x_q, src_x_d;
  logic [8:0]         src_y_q, src_y_d;

  logic signed [80:0] xw, yw, mac_x, mac_y;
  logic signed [72:0] xd, yd, mac_d;
  logic [80:0]        abs_x, abs_y;
  logic [72:0]        abs_d;
  logic [W-1:0]       trial;
  logic               done_ok;

  always_comb begin
    xw    = 81'(x_q);
    yw    = 81'(y_q);
    xd    = 73'(x_q);
    yd    = 73'(y_q);
    mac_x = 81'(c1_q) * xw + 81'(c2_q) * yw + 81'(c3_q);
    mac_y = 81'(c4_q) * xw + 81'(c5_q) * yw + 81'(c6_q);
    mac_d = 73'(c7_q) * xd + 73'(c8_q) * yd + 73'(c9_q);
  end

  assign abs_x   = numx_q[80] ? -numx_q : numx_q;
  assign abs_y   = numy_q[80] ? -numy_q : numy_q;
  assign abs_d   = den_q[72]  ? -den_q  : den_q;
  assign trial   = W'(den_q) << cnt_q;
  assign done_ok = ~bad_x_q & ~bad_y_q & (qx_q <= X_LIM) & (qy_q <= Y_LIM);

  always_comb begin
    state_d = state_q;
    x_d = x_q;   y_d = y_q;
    c1_d = c1_q; c2_d = c2_q; c3_d = c3_q;
    c4_d = c4_q; c5_d = c5_q; c6_d = c6_q;
    c7_d = c7_q; c8_d = c8_q; c9_d = c9_q;
    numx_d = numx_q; numy_d = numy_q; den_d = den_q;
    bad_x_d = bad_x_q; bad_y_d = bad_y_q;
    qx_d = qx_q; qy_d = qy_q; cnt_d = cnt_q;
    out_valid_d = 1'b0;
    src_ok_d = src_ok_q; src_x_d = src_x_q; src_y_d = src_y_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        x_d = req_x; y_d = req_y;
        c1_d = p1_inv; c2_d = p2_inv; c3_d = p3_inv;
        c4_d = p4_inv; c5_d = p5_inv; c6_d = p6_inv;
        c7_d = p7_inv; c8_d = p8_inv; c9_d = p9_inv;
        state_d = S_MAC;
      end
      S_MAC: begin
        numx_d = mac_x; numy_d = mac_y; den_d = mac_d;
        state_d = S_PREP;
      end
      S_PREP: begin
        // a negative quotient or one that needs more than QBITS bits is unrepresentable
        bad_x_d = (den_q == '0) | ((numx_q != '0) & (numx_q[80] != den_q[72])) |
                  (W'(abs_x) >= {abs_d, {QBITS{1'b0}}});
        bad_y_d = (den_q == '0) | ((numy_q != '0) & (numy_q[80] != den_q[72])) |
                  (W'(abs_y) >= {abs_d, {QBITS{1'b0}}});
        numx_d = abs_x; numy_d = abs_y; den_d = abs_d;
        qx_d = '0; qy_d = '0;
        cnt_d = CW'(QBITS - 1);
        state_d = S_DIV;
      end
      S_DIV: begin
        if (W'(numx_q) >= trial) begin
          numx_d = numx_q - 81'(trial);
          qx_d[cnt_q] = 1'b1;
        end
        if (W'(numy_q) >= trial) begin
          numy_d = numy_q - 81'(trial);
          qy_d[cnt_q] = 1'b1;
        end
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d = cnt_q - 1'b1;
      end
      S_DONE: begin
        src_ok_d    = done_ok;
        src_x_d     = done_ok ? qx_q[9:0] : '0;
        src_y_d     = done_ok ? qy_q[8:0] : '0;
        out_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      x_q <= '0; y_q <= '0;
      c1_q <= '0; c2_q <= '0; c3_q <= '0;
      c4_q <= '0; c5_q <= '0; c6_q <= '0;
      c7_q <= '0; c8_q <= '0; c9_q <= '0;
      numx_q <= '0; numy_q <= '0; den_q <= '0;
      bad_x_q <= 1'b0; bad_y_q <= 1'b0;
      qx_q <= '0; qy_q <= '0; cnt_q <= '0;
      out_valid_q <= 1'b0; src_ok_q <= 1'b0;
      src_x_q <= '0; src_y_q <= '0;
    end else begin
      state_q <= state_d;
      x_q <= x_d; y_q <= y_d;
      c1_q <= c1_d; c2_q <= c2_d; c3_q <= c3_d;
      c4_q <= c4_d; c5_q <= c5_d; c6_q <= c6_d;
      c7_q <= c7_d; c8_q <= c8_d; c9_q <= c9_d;
      numx_q <= numx_d; numy_q <= numy_d; den_q <= den_d;
      bad_x_q <= bad_x_d; bad_y_q <= bad_y_d;
      qx_q <= qx_d; qy_q <= qy_d; cnt_q <= cnt_d;
      out_valid_q <= out_valid_d; src_ok_q <= src_ok_d;
      src_x_q <= src_x_d; src_y_q <= src_y_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign src_ok    = src_ok_q;
  assign src_x     = src_x_q;
  assign src_y     = src_y_q;
endmodule

// File: tb/tb_perspective_pixel_map.sv
// Bench for perspective_pixel_map: directed corner pixels plus randomized coefficient
// sets compared against a wide-integer division model of the mapping.
module tb_perspective_pixel_map;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, out_valid, src_ok;
  logic [9:0]  req_x, src_x;
  logic [8:0]  req_y, src_y;
  logic signed [127:0] c [1:9];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  perspective_pixel_map dut (
    .clk(clk), .reset(reset),
    .p1_inv(c[1][67:0]), .p2_inv(c[2][68:0]), .p3_inv(c[3][78:0]),
    .p4_inv(c[4][67:0]), .p5_inv(c[5][68:0]), .p6_inv(c[6][78:0]),
    .p7_inv(c[7][58:0]), .p8_inv(c[8][59:0]), .p9_inv(c[9][70:0]),
    .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .req_ready(req_ready),
    .out_valid(out_valid), .src_x(src_x), .src_y(src_y), .src_ok(src_ok)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_c(input longint a1, a2, a3, a4, a5, a6, a7, a8, a9);
    c[1] = a1; c[2] = a2; c[3] = a3; c[4] = a4; c[5] = a5;
    c[6] = a6; c[7] = a7; c[8] = a8; c[9] = a9;
  endtask

  function automatic logic [19:0] pk(input logic ok, input int x, input int y);
    return {ok, 10'(x), 9'(y)};
  endfunction

  // Reference: exact signed rational mapping with the legality rules applied.
  function automatic logic [19:0] ref_map(input int X, input int Y);
    logic signed [127:0] nx, ny, d, qx, qy;
    logic okx, oky;
    nx = c[1] * X + c[2] * Y + c[3];
    ny = c[4] * X + c[5] * Y + c[6];
    d  = c[7] * X + c[8] * Y + c[9];
    if (d == 0) return '0;
    qx = nx / d;
    qy = ny / d;
    okx = (nx == 0 || ((nx < 0) == (d < 0))) && qx <= 639;
    oky = (ny == 0 || ((ny < 0) == (d < 0))) && qy <= 479;
    if (okx && oky) return {1'b1, qx[9:0], qy[8:0]};
    return '0;
  endfunction

  function automatic longint jit();
    return longint'($urandom_range(0, 2047)) - 1024;
  endfunction

  task automatic run_pix(input int X, input int Y, input logic [19:0] exp,
                         input string tag, input bit scramble);
    int k;
    logic [19:0] res;
    @(negedge clk);
    req_x = 10'(X); req_y = 9'(Y); req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 40) begin @(negedge clk); k++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    if (scramble) set_c(0, 0, 0, 0, 0, 0, 0, 0, 0);
    k = 0;
    while (!out_valid && k < 40) begin @(negedge clk); k++; end
    chk({tag, "_lat"}, 64'(k), 64'd14);
    res = {src_ok, src_x, src_y};
    chk({tag, "_res"}, 64'(res), 64'(exp));
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(out_valid), 64'd0);
    chk({tag, "_hold"}, 64'({src_ok, src_x, src_y}), 64'(exp));
  endtask

  initial begin
    int k, cnt;
    longint K, t [1:9];
    int sh;
    bit neg;
    int X, Y;
    reset = 1'b1; req_valid = 1'b0; req_x = '0; req_y = '0;
    set_c(1, 0, 0, 0, 1, 0, 0, 0, 1);
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_res", 64'({src_ok, src_x, src_y}), 64'd0);
    reset = 1'b0;

    run_pix(100, 50, pk(1, 100, 50), "identity", 0);
    run_pix(0, 0, pk(1, 0, 0), "zero_num", 0);
    run_pix(639, 479, pk(1, 639, 479), "max_corner", 0);
    run_pix(7, 8, pk(1, 7, 8), "coef_latched", 1);
    set_c(1, 0, 1, 0, 1, 0, 0, 0, 1);
    run_pix(639, 479, pk(0, 0, 0), "x_640", 0);
    set_c(1, 0, 0, 0, 1, 0, 0, 0, 2);
    run_pix(101, 51, pk(1, 50, 25), "scale_trunc", 0);
    set_c(0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_pix(100, 50, pk(0, 0, 0), "den_zero", 0);
    set_c(1, 0, -1000, 0, 1, 0, 0, 0, 1);
    run_pix(10, 50, pk(0, 0, 0), "neg_x", 0);
    set_c(4096, 0, 0, 0, 1, 0, 0, 0, 1);
    run_pix(1, 50, pk(0, 0, 0), "q_overflow", 0);
    set_c(-1, 0, 0, 0, -1, 0, 0, 0, -1);
    run_pix(200, 100, pk(1, 200, 100), "all_neg", 0);
    set_c(0, 0, -1, 0, 1, 0, 0, 0, 5);
    run_pix(0, 3, pk(0, 0, 0), "neg_frac", 0);

    // request held while busy: ignored until IDLE, then accepted
    set_c(1, 0, 0, 0, 1, 0, 0, 0, 1);
    @(negedge clk);
    req_x = 10'd20; req_y = 9'd30; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; k = 0;
    repeat (5) begin @(negedge clk); k++; end
    chk("busy_ready", 64'(req_ready), 64'd0);
    req_x = 10'd40; req_y = 9'd60; req_valid = 1'b1;
    while (!out_valid && k < 60) begin @(negedge clk); k++; end
    chk("busy_a_lat", 64'(k), 64'd14);
    chk("busy_a_res", 64'({src_ok, src_x, src_y}), 64'(pk(1, 20, 30)));
    @(negedge clk); k++;
    req_valid = 1'b0;
    while (!out_valid && k < 60) begin @(negedge clk); k++; end
    chk("busy_b_lat", 64'(k), 64'd29);
    chk("busy_b_res", 64'({src_ok, src_x, src_y}), 64'(pk(1, 40, 60)));

    // reset mid-division
    @(negedge clk);
    req_x = 10'd5; req_y = 9'd5; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_res", 64'({src_ok, src_x, src_y}), 64'd0);
    chk("midrst_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    repeat (30) begin @(negedge clk); if (out_valid) cnt++; end
    chk("midrst_nopulse", 64'(cnt), 64'd0);
    run_pix(3, 4, pk(1, 3, 4), "post_rst", 0);

    // randomized coefficient sets
    for (int n = 0; n < 1000; n++) begin
      K = longint'($urandom_range(1, 1 << 20));
      sh = int'($urandom_range(0, 45));
      neg = 1'($urandom_range(0, 1));
      t[1] = K * longint'($urandom_range(0, 2)) + jit();
      t[2] = K * longint'($urandom_range(0, 1)) + jit();
      t[3] = K * (longint'($urandom_range(0, 800)) - 200);
      t[4] = K * longint'($urandom_range(0, 1)) + jit();
      t[5] = K * longint'($urandom_range(0, 2)) + jit();
      t[6] = K * (longint'($urandom_range(0, 600)) - 150);
      t[7] = jit();
      t[8] = jit();
      t[9] = K * longint'($urandom_range(1, 3)) + jit();
      for (int i = 1; i <= 9; i++) begin
        c[i] = neg ? -t[i] : t[i];
        c[i] = c[i] <<< sh;
      end
      X = int'($urandom_range(0, 639));
      Y = int'($urandom_range(0, 479));
      run_pix(X, Y, ref_map(X, Y), "rand", 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
